datapath_gen2: RTL and testbench
================================

Name: datapath_gen2

Overview:
- Parametrised successor to the single-bus CPU datapath.
- Contents: register file, PC, MAR, MDR, Y, Z (hi/lo), HI/LO, in/out ports and an ALU, all joined by one internal bus.
- The bus source is chosen by an encoded select, so bus contention cannot occur.
- MUL/DIV run on an iterative multi-cycle engine with a start/busy/done handshake, in place of the combinational 64-bit ALU.

Parameters:
WIDTH, 32, datapath/bus width in bits (power of 2, >=8)
NREGS, 16, general registers; RIDX_W = clog2(NREGS)
ADDR_W, 9, memory address bits taken from MAR[ADDR_W-1:0]

Ports:
clock  in  1  rising-edge clock
clear  in  1  reset, asynchronous, active-low
src_sel  in  4  bus source: 0 none (bus=0), 1 REG, 2 PC, 3 MDR, 4 HI, 5 LO, 6 ZHI, 7 ZLO, 8 INPORT, 9 CSIGN; 10-15 give bus=0
src_reg  in  RIDX_W  register read index when src_sel=REG
csign_in  in  WIDTH  sign-extended immediate from select/encode logic
dst_we  in  1  write bus into register dst_reg
dst_reg  in  RIDX_W  register write index
pc_in, mar_in, y_in, hi_in, lo_in, out_in  in  1 each  load the named register from bus
mdr_in  in  1  load MDR (source chosen by mdr_rd)
mdr_rd  in  1  MDR source: 1 mem_rdata, 0 bus
ip_in  in  1  load inport from in_port
in_port  in  WIDTH  external input unit
z_in  in  1  latch single-cycle ALU result into Z
alu_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHL, 5 SHR, 6 SHRA, 7 ROL, 8 ROR, 9 NEG, 10 NOT, 11 INC, 12 MUL, 13 DIV, 14-15 PASSB
md_start  in  1  start MUL/DIV (alu_op 12/13 only)
md_busy  out  1  engine running
md_done  out  1  one-cycle pulse on the cycle after Z is written
div0  out  1  sticky; set when DIV has divisor 0, cleared by next md_start
bus_out  out  WIDTH  current bus value
pc_q  out  WIDTH  PC value
mem_addr  out  ADDR_W  MAR[ADDR_W-1:0]
mem_wdata  out  WIDTH  MDR value
mem_rdata  in  WIDTH  RAM read data
out_port  out  WIDTH  outport register

Behaviour:
- Reset: while clear=0, every register is 0, including the register file, Z, the engine state and div0; md_busy=0, md_done=0. An in-flight MUL/DIV is aborted and writes nothing.
- Bus: purely combinational from src_sel, src_reg and register Q values.
  - A register written this edge appears on the bus from the next cycle.
  - Read and write of the same register in one cycle puts the old value on the bus.
- ALU operands: A=Y, B=bus.
  - Single-cycle ops are latched on a z_in edge: Z_lo=result, Z_hi=0.
  - Shift/rotate amounts are B[clog2(WIDTH)-1:0]; SHRA is arithmetic.
  - NEG = -B; NOT = ~B; INC = B+1; ADD/SUB wrap modulo 2^WIDTH.
- MUL/DIV:
  - md_start at edge k samples A and B into the engine; md_busy=1 from k through k+WIDTH.
  - At edge k+WIDTH: Z is written, md_busy falls, md_done=1 for one cycle.
  - MUL: signed product; Z_hi/Z_lo = upper/lower WIDTH bits.
  - DIV: signed, truncating toward zero; Z_lo = quotient, Z_hi = remainder (sign follows dividend).
  - Divisor 0: Z_lo = all-ones, Z_hi = dividend, div0=1. Most-negative / -1: Z_lo = most-negative, Z_hi = 0.
- Priority and conflicts:
  - md_start while md_busy: ignored.
  - z_in while md_busy: ignored.
  - md_start and z_in together: md_start wins.
  - md_start with alu_op not 12/13: ignored.
  - While busy, Z reads return the prior Z.
- MDR: on mdr_in, loads mem_rdata if mdr_rd=1, else bus.

Optional Feature:
R0_ZERO_EN:
- Defined: register 0 is hardwired to zero; dst_we to index 0 is ignored; REG reads of index 0 return 0.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Package datapath_pkg: src_sel and alu_op encodings as typed constants, opcode width, default WIDTH/NREGS/ADDR_W.
- One sub-module, md_unit: iterative radix-2 signed multiply/divide with start/busy/done; WIDTH parameter.

Test Plan:
1. Start MUL (Y=3, bus=5), drive clear=0 at cycle 10 -> md_busy=0, Z=0, all registers 0, no md_done; after release, bus=0 with src_sel=0.
2. CSIGN=5 -> R4; Y<-R4; bus=CSIGN 0xFFFFFFFD, ADD, z_in -> ZLO on bus = 0x00000002, ZHI = 0.
3. Y=0xFFFFFFFD, bus=7, MUL start -> md_busy for 32 cycles, one md_done pulse; Z_hi=0xFFFFFFFF, Z_lo=0xFFFFFFEB; a second md_start mid-run is ignored.
4. Y=-17, bus=5, DIV -> Z_lo=0xFFFFFFFD, Z_hi=0xFFFFFFFE. Then Y=9, bus=0 -> div0=1, Z_lo=0xFFFFFFFF, Z_hi=9; next start clears div0.
5. mar_in with bus=0x1234 -> mem_addr=0x034. mdr_rd=1, mem_rdata=0xCAFEF00D, mdr_in; src_sel=MDR -> bus_out=0xCAFEF00D; mdr_rd=0 loads bus into MDR -> mem_wdata follows.
6. dst_we to R0 with bus=0xA5A5A5A5 -> reads 0 with R0_ZERO_EN, 0xA5A5A5A5 without. Same-cycle write/read of R7 shows the old value on the bus.

Source files
------------

// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module      : datapath_pkg
// Description : Shared encodings and defaults for the datapath_gen2 slice:
//               bus-source selects, ALU opcodes and the MUL/DIV engine state.
// Revision    : 1.0 - initial release
// ============================================================================
package datapath_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_NREGS  = 16;
    localparam int DEF_ADDR_W = 9;
    localparam int SEL_W      = 4;
    localparam int OP_W       = 4;

    localparam logic [SEL_W-1:0] SRC_NONE   = 4'd0;
    localparam logic [SEL_W-1:0] SRC_REG    = 4'd1;
    localparam logic [SEL_W-1:0] SRC_PC     = 4'd2;
    localparam logic [SEL_W-1:0] SRC_MDR    = 4'd3;
    localparam logic [SEL_W-1:0] SRC_HI     = 4'd4;
    localparam logic [SEL_W-1:0] SRC_LO     = 4'd5;
    localparam logic [SEL_W-1:0] SRC_ZHI    = 4'd6;
    localparam logic [SEL_W-1:0] SRC_ZLO    = 4'd7;
    localparam logic [SEL_W-1:0] SRC_INPORT = 4'd8;
    localparam logic [SEL_W-1:0] SRC_CSIGN  = 4'd9;

    localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [OP_W-1:0] ALU_AND  = 4'd2;
    localparam logic [OP_W-1:0] ALU_OR   = 4'd3;
    localparam logic [OP_W-1:0] ALU_SHL  = 4'd4;
    localparam logic [OP_W-1:0] ALU_SHR  = 4'd5;
    localparam logic [OP_W-1:0] ALU_SHRA = 4'd6;
    localparam logic [OP_W-1:0] ALU_ROL  = 4'd7;
    localparam logic [OP_W-1:0] ALU_ROR  = 4'd8;
    localparam logic [OP_W-1:0] ALU_NEG  = 4'd9;
    localparam logic [OP_W-1:0] ALU_NOT  = 4'd10;
    localparam logic [OP_W-1:0] ALU_INC  = 4'd11;
    localparam logic [OP_W-1:0] ALU_MUL  = 4'd12;
    localparam logic [OP_W-1:0] ALU_DIV  = 4'd13;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

endpackage
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_unit
// Description : Iterative radix-2 signed multiply / divide engine. Works on
//               operand magnitudes for WIDTH steps and fixes signs at the end.
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit
    import datapath_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic             fin,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CNT_W = $clog2(WIDTH);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, bz_q, bz_d;
    logic             done_q, done_d, div0_q, div0_d;
    logic [WIDTH-1:0] dvd_q, dvd_d, lq_q, lq_d, m_q, m_d;
    logic [WIDTH:0]   acc_q, acc_d;

    logic [WIDTH:0]     mul_sum, div_sh, div_trial, step_acc;
    logic [WIDTH-1:0]   step_lq, a_mag, b_mag, quo, rem;
    logic [2*WIDTH-1:0] prod_mag, prod;

    assign busy = (state_q == MD_RUN);
    assign done = done_q;
    assign div0 = div0_q;
    assign fin  = (state_q == MD_RUN) && (cnt_q == CNT_W'(WIDTH - 1));

    // One shift-add (MUL) or restoring shift-subtract (DIV) step per cycle.
    always_comb begin
        a_mag     = a[WIDTH-1] ? -a : a;
        b_mag     = b[WIDTH-1] ? -b : b;
        mul_sum   = acc_q + (lq_q[0] ? {1'b0, m_q} : '0);
        div_sh    = {acc_q[WIDTH-1:0], lq_q[WIDTH-1]};
        div_trial = div_sh - {1'b0, m_q};
        if (div_q) begin
            if (!div_trial[WIDTH]) begin
                step_acc = div_trial;
                step_lq  = {lq_q[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = div_sh;
                step_lq  = {lq_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_acc = {1'b0, mul_sum[WIDTH:1]};
            step_lq  = {mul_sum[0], lq_q[WIDTH-1:1]};
        end
        prod_mag = {step_acc[WIDTH-1:0], step_lq};
        prod     = neg_q ? -prod_mag : prod_mag;
        quo      = neg_q ? -step_lq : step_lq;
        rem      = rneg_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
        if (!div_q) begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (bz_q) begin
            res_hi = dvd_q;
            res_lo = '1;
        end else begin
            res_hi = rem;
            res_lo = quo;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        bz_d    = bz_q;
        dvd_d   = dvd_q;
        lq_d    = lq_q;
        m_d     = m_q;
        acc_d   = acc_q;
        done_d  = 1'b0;
        div0_d  = div0_q;
        if (start && (state_q == MD_IDLE)) begin
            state_d = MD_RUN;
            cnt_d   = '0;
            div_d   = is_div;
            neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
            rneg_d  = a[WIDTH-1];
            bz_d    = (b == '0);
            dvd_d   = a;
            acc_d   = '0;
            lq_d    = is_div ? a_mag : b_mag;
            m_d     = is_div ? b_mag : a_mag;
            div0_d  = 1'b0;
        end else if (state_q == MD_RUN) begin
            acc_d = step_acc;
            lq_d  = step_lq;
            cnt_d = cnt_q + CNT_W'(1);
            if (fin) begin
                state_d = MD_IDLE;
                done_d  = 1'b1;
                if (div_q && bz_q) div0_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            bz_q    <= 1'b0;
            dvd_q   <= '0;
            lq_q    <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            bz_q    <= bz_d;
            dvd_q   <= dvd_d;
            lq_q    <= lq_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/datapath_gen2.sv
`default_nettype none
// ============================================================================
// Module      : datapath_gen2
// Description : Single-bus CPU datapath with encoded bus source select and an
//               iterative MUL/DIV engine. Define R0_ZERO_EN to hardwire R0=0.
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_gen2
    import datapath_pkg::*;
#(
    parameter  int WIDTH  = DEF_WIDTH,
    parameter  int NREGS  = DEF_NREGS,
    parameter  int ADDR_W = DEF_ADDR_W,
    localparam int RIDX_W = $clog2(NREGS)
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [SEL_W-1:0]  src_sel,
    input  logic [RIDX_W-1:0] src_reg,
    input  logic [WIDTH-1:0]  csign_in,
    input  logic              dst_we,
    input  logic [RIDX_W-1:0] dst_reg,
    input  logic              pc_in,
    input  logic              mar_in,
    input  logic              y_in,
    input  logic              hi_in,
    input  logic              lo_in,
    input  logic              out_in,
    input  logic              mdr_in,
    input  logic              mdr_rd,
    input  logic              ip_in,
    input  logic [WIDTH-1:0]  in_port,
    input  logic              z_in,
    input  logic [OP_W-1:0]   alu_op,
    input  logic              md_start,
    output logic              md_busy,
    output logic              md_done,
    output logic              div0,
    output logic [WIDTH-1:0]  bus_out,
    output logic [WIDTH-1:0]  pc_q,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic [WIDTH-1:0]  out_port
);

    localparam int SH_W = $clog2(WIDTH);

    logic [WIDTH-1:0]  regs_q [NREGS];
    logic [WIDTH-1:0]  regs_d [NREGS];
    logic [WIDTH-1:0]  pc_d, mdr_q, mdr_d, y_q, y_d, hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]  zhi_q, zhi_d, zlo_q, zlo_d, inport_q, inport_d, outport_q, outport_d;
    logic [ADDR_W-1:0] mar_q, mar_d;

    logic [WIDTH-1:0]   bus, reg_rd, alu_res, md_hi, md_lo;
    logic [SH_W-1:0]    shamt;
    logic [2*WIDTH-1:0] rol_w, ror_w;
    logic               md_go, md_fin;

    assign bus_out   = bus;
    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;
    assign out_port  = outport_q;

    always_comb begin
        reg_rd = regs_q[src_reg];
`ifdef R0_ZERO_EN
        if (src_reg == '0) reg_rd = '0;
`endif
        case (src_sel)
            SRC_NONE:   bus = '0;
            SRC_REG:    bus = reg_rd;
            SRC_PC:     bus = pc_q;
            SRC_MDR:    bus = mdr_q;
            SRC_HI:     bus = hi_q;
            SRC_LO:     bus = lo_q;
            SRC_ZHI:    bus = zhi_q;
            SRC_ZLO:    bus = zlo_q;
            SRC_INPORT: bus = inport_q;
            SRC_CSIGN:  bus = csign_in;
            default:    bus = '0;
        endcase
    end

    // Rotates take the matching half of a doubled operand after a plain shift.
    always_comb begin
        shamt = bus[SH_W-1:0];
        rol_w = {y_q, y_q} << shamt;
        ror_w = {y_q, y_q} >> shamt;
        case (alu_op)
            ALU_ADD:  alu_res = y_q + bus;
            ALU_SUB:  alu_res = y_q - bus;
            ALU_AND:  alu_res = y_q & bus;
            ALU_OR:   alu_res = y_q | bus;
            ALU_SHL:  alu_res = y_q << shamt;
            ALU_SHR:  alu_res = y_q >> shamt;
            ALU_SHRA: alu_res = $signed(y_q) >>> shamt;
            ALU_ROL:  alu_res = rol_w[2*WIDTH-1:WIDTH];
            ALU_ROR:  alu_res = ror_w[WIDTH-1:0];
            ALU_NEG:  alu_res = -bus;
            ALU_NOT:  alu_res = ~bus;
            ALU_INC:  alu_res = bus + WIDTH'(1);
            default:  alu_res = bus;
        endcase
    end

    assign md_go = md_start && !md_busy && ((alu_op == ALU_MUL) || (alu_op == ALU_DIV));

    md_unit #(
        .WIDTH (WIDTH)
    ) u_md_unit (
        .clk    (clock),
        .rst_n  (clear),
        .start  (md_go),
        .is_div (alu_op == ALU_DIV),
        .a      (y_q),
        .b      (bus),
        .busy   (md_busy),
        .done   (md_done),
        .div0   (div0),
        .fin    (md_fin),
        .res_hi (md_hi),
        .res_lo (md_lo)
    );

    always_comb begin
        regs_d = regs_q;
`ifdef R0_ZERO_EN
        if (dst_we && (dst_reg != '0)) regs_d[dst_reg] = bus;
`else
        if (dst_we) regs_d[dst_reg] = bus;
`endif
        pc_d      = pc_in  ? bus : pc_q;
        mar_d     = mar_in ? bus[ADDR_W-1:0] : mar_q;
        y_d       = y_in   ? bus : y_q;
        hi_d      = hi_in  ? bus : hi_q;
        lo_d      = lo_in  ? bus : lo_q;
        outport_d = out_in ? bus : outport_q;
        inport_d  = ip_in  ? in_port : inport_q;
        mdr_d     = mdr_in ? (mdr_rd ? mem_rdata : bus) : mdr_q;
        zhi_d     = zhi_q;
        zlo_d     = zlo_q;
        // z_in is locked out while the engine runs and when a start is accepted.
        if (md_fin) begin
            zhi_d = md_hi;
            zlo_d = md_lo;
        end else if (z_in && !md_busy && !md_go) begin
            zhi_d = '0;
            zlo_d = alu_res;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            pc_q      <= '0;
            mar_q     <= '0;
            mdr_q     <= '0;
            y_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            zhi_q     <= '0;
            zlo_q     <= '0;
            inport_q  <= '0;
            outport_q <= '0;
        end else begin
            regs_q    <= regs_d;
            pc_q      <= pc_d;
            mar_q     <= mar_d;
            mdr_q     <= mdr_d;
            y_q       <= y_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            zhi_q     <= zhi_d;
            zlo_q     <= zlo_d;
            inport_q  <= inport_d;
            outport_q <= outport_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_datapath_gen2.sv
`default_nettype none
// ============================================================================
// Module      : tb_datapath_gen2
// Description : Self-checking bench for datapath_gen2 (honours R0_ZERO_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_gen2;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          clear = 1'b0;
    logic [3:0]    src_sel = '0, src_reg = '0, dst_reg = '0, alu_op = '0;
    logic [W-1:0]  csign_in = '0, in_port = '0, mem_rdata = '0;
    logic          dst_we = 0, pc_in = 0, mar_in = 0, y_in = 0, hi_in = 0, lo_in = 0, out_in = 0;
    logic          mdr_in = 0, mdr_rd = 0, ip_in = 0, z_in = 0, md_start = 0;
    logic          md_busy, md_done, div0;
    logic [W-1:0]  bus_out, pc_q, mem_wdata, out_port;
    logic [8:0]    mem_addr;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] zhi_m = '0, zlo_m = '0;
    logic [W-1:0] regs_m [16];

    datapath_gen2 dut (
        .clock(clock), .clear(clear), .src_sel(src_sel), .src_reg(src_reg), .csign_in(csign_in),
        .dst_we(dst_we), .dst_reg(dst_reg), .pc_in(pc_in), .mar_in(mar_in), .y_in(y_in),
        .hi_in(hi_in), .lo_in(lo_in), .out_in(out_in), .mdr_in(mdr_in), .mdr_rd(mdr_rd),
        .ip_in(ip_in), .in_port(in_port), .z_in(z_in), .alu_op(alu_op), .md_start(md_start),
        .md_busy(md_busy), .md_done(md_done), .div0(div0), .bus_out(bus_out), .pc_q(pc_q),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .out_port(out_port)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic idle();
        src_sel = 0; src_reg = 0; dst_we = 0; dst_reg = 0; alu_op = 0; csign_in = 0;
        pc_in = 0; mar_in = 0; y_in = 0; hi_in = 0; lo_in = 0; out_in = 0;
        mdr_in = 0; mdr_rd = 0; ip_in = 0; z_in = 0; md_start = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_csign(input logic [W-1:0] v);
        src_sel = 4'd9;
        csign_in = v;
    endtask

    task automatic rd(input logic [3:0] sel, input logic [3:0] r, output logic [W-1:0] v);
        idle();
        src_sel = sel;
        src_reg = r;
        #1;
        v = bus_out;
    endtask

    task automatic load_reg(input logic [3:0] r, input logic [W-1:0] v);
        idle(); drive_csign(v); dst_we = 1; dst_reg = r; tick(); idle();
        regs_m[r] = v;
    endtask

    task automatic set_y(input logic [W-1:0] v);
        idle(); drive_csign(v); y_in = 1; tick(); idle();
    endtask

    task automatic check_z(input string tag);
        logic [W-1:0] v;
        rd(4'd7, 4'd0, v); check({tag, "_zlo"}, v, zlo_m);
        rd(4'd6, 4'd0, v); check({tag, "_zhi"}, v, zhi_m);
    endtask

    function automatic logic [W-1:0] alu_ref(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        int s;
        logic [W-1:0] r;
        s = int'(b & 32'd31);
        r = a;
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a << s;
            5: return a >> s;
            6: return $signed(a) >>> s;
            7: begin repeat (s) r = {r[W-2:0], r[W-1]}; return r; end
            8: begin repeat (s) r = {r[0], r[W-1:1]}; return r; end
            9: return -b;
            10: return ~b;
            11: return b + 1;
            default: return b;
        endcase
    endfunction

    task automatic md_ref(input logic is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] hi, output logic [W-1:0] lo);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!is_div) begin
            p = sa * sb;
            hi = p[63:32]; lo = p[31:0];
        end else if (b == 0) begin
            lo = '1; hi = a;
        end else begin
            q = sa / sb; r = sa % sb;
            lo = q[31:0]; hi = r[31:0];
        end
    endtask

    task automatic run_md(input logic is_div, input logic [W-1:0] a, input logic [W-1:0] b, input logic poke);
        logic [W-1:0] eh, el, v;
        int busy_cycles, done_seen;
        md_ref(is_div, a, b, eh, el);
        set_y(a);
        drive_csign(b); alu_op = is_div ? 4'd13 : 4'd12; md_start = 1;
        tick(); idle();
        check_bit("md_busy_at_start", md_busy, 1'b1);
        check_bit("div0_cleared_by_start", div0, 1'b0);
        busy_cycles = 1;
        done_seen = 0;
        for (int j = 1; j < W; j++) begin
            if (poke && j == 5) begin
                drive_csign(32'h55); alu_op = is_div ? 4'd12 : 4'd13; md_start = 1;
            end
            if (poke && j == 7) begin
                drive_csign(32'h77); alu_op = 4'd0; z_in = 1;
            end
            if (j == W / 2) begin
                src_sel = 4'd7; #1;
                check("z_held_while_busy", bus_out, zlo_m);
            end
            tick(); idle();
            if (md_busy) busy_cycles++;
            if (md_done) done_seen++;
        end
        check("md_busy_cycles", 32'(busy_cycles), 32'(W));
        check("md_done_early", 32'(done_seen), 32'd0);
        tick();
        check_bit("md_busy_fall", md_busy, 1'b0);
        check_bit("md_done_pulse", md_done, 1'b1);
        tick();
        check_bit("md_done_one_cycle", md_done, 1'b0);
        zhi_m = eh; zlo_m = el;
        check_z(is_div ? "div" : "mul");
        check_bit("div0_flag", div0, is_div && (b == 0));
        rd(4'd0, 4'd0, v);
    endtask

    initial begin
        logic [W-1:0] v, a, b;
        int op, r, dones;
        for (int i = 0; i < 16; i++) regs_m[i] = '0;
        idle();
        clear = 0;
        repeat (3) tick();
        clear = 1;
        tick();

        // Reset values and abort of an in-flight multiply.
        load_reg(4'd3, 32'hDEAD_BEEF);
        idle(); drive_csign(32'h1000); pc_in = 1; tick(); idle();
        set_y(32'd3);
        drive_csign(32'd5); alu_op = 4'd12; md_start = 1; tick(); idle();
        repeat (9) tick();
        #2 clear = 0;
        #1;
        check_bit("rst_md_busy", md_busy, 1'b0);
        check_bit("rst_md_done", md_done, 1'b0);
        check_bit("rst_div0", div0, 1'b0);
        check("rst_pc", pc_q, 32'h0);
        check("rst_out_port", out_port, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_addr", {23'h0, mem_addr}, 32'h0);
        for (int i = 0; i < 16; i++) begin
            rd(4'd1, 4'(i), v);
            check("rst_reg", v, 32'h0);
        end
        regs_m[3] = '0;
        check_z("rst");
        repeat (2) tick();
        #2 clear = 1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (md_done) dones++;
        end
        check("rst_no_done", 32'(dones), 32'd0);
        rd(4'd0, 4'd0, v);
        check("bus_none", v, 32'h0);
        rd(4'd12, 4'd0, v);
        check("bus_unused_sel", v, 32'h0);
        idle(); drive_csign(32'h10); alu_op = 4'd0; z_in = 1; tick(); idle();
        zlo_m = 32'h10; zhi_m = 0;
        check_z("rst_y_zero");

        // Directed ADD through register file and Y.
        load_reg(4'd4, 32'd5);
        idle(); src_sel = 4'd1; src_reg = 4'd4; y_in = 1; tick(); idle();
        drive_csign(32'hFFFF_FFFD); alu_op = 4'd0; z_in = 1; tick(); idle();
        zlo_m = 32'h2; zhi_m = 0;
        check_z("add_directed");

        // Random single-cycle ALU operations.
        for (int i = 0; i < 24; i++) begin
            a = $urandom; b = $urandom;
            op = $urandom_range(0, 15);
            if (op == 12 || op == 13) op = 14;
            if (i < 12) op = i;
            set_y(a);
            drive_csign(b); alu_op = 4'(op); z_in = 1; tick(); idle();
            zlo_m = alu_ref(op, a, b); zhi_m = 0;
            check_z($sformatf("alu_op%0d", op));
        end

        // MUL / DIV: directed corners, then random operands.
        run_md(1'b0, 32'hFFFF_FFFD, 32'd7, 1'b1);
        run_md(1'b1, -32'sd17, 32'd5, 1'b0);
        run_md(1'b1, 32'd9, 32'd0, 1'b0);
        run_md(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_md(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        for (int i = 0; i < 6; i++) begin
            a = $urandom; b = $urandom;
            if (i == 2) b = b >> 20;
            run_md(1'(i & 1), a, b, 1'b0);
        end

        // MAR / MDR / PC / HI / LO / ports.
        idle(); drive_csign(32'h1234); mar_in = 1; tick(); idle();
        check("mem_addr", {23'h0, mem_addr}, 32'h034);
        mem_rdata = 32'hCAFE_F00D;
        idle(); mdr_rd = 1; mdr_in = 1; tick(); idle();
        rd(4'd3, 4'd0, v);
        check("mdr_from_mem", v, 32'hCAFE_F00D);
        idle(); drive_csign(32'h1357_2468); mdr_in = 1; tick(); idle();
        check("mdr_from_bus", mem_wdata, 32'h1357_2468);
        idle(); drive_csign(32'hABCD_0001); pc_in = 1; out_in = 1; hi_in = 1; tick(); idle();
        check("pc_load", pc_q, 32'hABCD_0001);
        check("out_port", out_port, 32'hABCD_0001);
        idle(); drive_csign(32'h0F0F_1234); lo_in = 1; tick(); idle();
        rd(4'd4, 4'd0, v); check("hi_bus", v, 32'hABCD_0001);
        rd(4'd5, 4'd0, v); check("lo_bus", v, 32'h0F0F_1234);
        rd(4'd2, 4'd0, v); check("pc_bus", v, 32'hABCD_0001);
        in_port = 32'h600D_CAFE;
        idle(); ip_in = 1; tick(); idle();
        rd(4'd8, 4'd0, v); check("inport_bus", v, 32'h600D_CAFE);

        // Random register file traffic.
        for (int i = 0; i < 12; i++) begin
            r = $urandom_range(1, 15);
            load_reg(4'(r), $urandom);
        end
        for (int i = 1; i < 16; i++) begin
            rd(4'd1, 4'(i), v);
            check($sformatf("reg%0d", i), v, regs_m[i]);
        end

        // R0 behaviour and same-cycle read/write.
        load_reg(4'd0, 32'hA5A5_A5A5);
        rd(4'd1, 4'd0, v);
`ifdef R0_ZERO_EN
        check("r0_read", v, 32'h0);
`else
        check("r0_read", v, 32'hA5A5_A5A5);
`endif
        load_reg(4'd7, 32'h1111_1111);
        idle(); src_sel = 4'd1; src_reg = 4'd7; dst_we = 1; dst_reg = 4'd7; #1;
        check("r7_same_cycle_old", bus_out, 32'h1111_1111);
        tick(); idle();
        load_reg(4'd7, 32'h2222_2222);
        rd(4'd1, 4'd7, v);
        check("r7_next_cycle_new", v, 32'h2222_2222);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
